counter_cmd_ctrl: RTL
=====================

COUNTER_CMD_CTRL -- requirements
Module: counter_cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, width of the switch data and data_in bus.
REQ-002 SHALL have parameter DEB_CYCLES, default 4, cycles a synchronized button must be stable before it is accepted.
REQ-003 SHALL have parameter TICK_DIV, default 10, clock cycles between count_en pulses in RUN.
REQ-004 SHALL have ports, one per line:
  Clk  input  1  single clock, all state on rising edge
  Reset  input  1  asynchronous, active-high reset
  btn_load  input  1  raw asynchronous button, load request
  btn_run  input  1  raw asynchronous button, run/stop toggle
  btn_dir  input  1  raw asynchronous button, direction toggle
  sw_data  input  WIDTH  raw switch value to load
  load  output  1  one-cycle load strobe to the downstream counter
  count_en  output  1  one-cycle count-enable pulse to the downstream counter
  up  output  1  count direction, 1 = up
  data_in  output  WIDTH  registered load value, valid while load=1
  running  output  1  high in state RUN

Function
REQ-005 SHALL pass each btn_* through a 2-flop synchronizer, then a per-button debouncer; the debounced level changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-006 SHALL generate a one-cycle press event on each 0->1 transition of a debounced level; a held button yields exactly one event.
REQ-007 SHALL register sw_data through a 2-flop synchronizer; data_in is taken from the synchronized value in the same cycle as the load event.
REQ-008 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-009 IDLE: load event -> LOAD; run event -> RUN; otherwise stay.
REQ-010 LOAD: load=1 for exactly one cycle, data_in holds the captured value; unconditionally -> IDLE next cycle.
REQ-011 RUN: load event -> LOAD (run stops); run event -> IDLE; otherwise stay.
REQ-012 SHALL run a prescaler counting 0..TICK_DIV-1, cleared on every entry to RUN; count_en=1 for one cycle when it reaches TICK_DIV-1 in RUN, then wraps to 0.
REQ-013 First count_en after entering RUN SHALL occur TICK_DIV cycles after the entry cycle.
REQ-014 count_en SHALL be 0 outside RUN, and load and count_en SHALL never be 1 in the same cycle.
REQ-015 A dir event SHALL invert up in any state, effective next cycle; it never changes state.
REQ-016 Simultaneous load and run events SHALL resolve to LOAD; run event is discarded.
REQ-017 All outputs SHALL be registered; event-to-output latency is 1 cycle after the press event.
REQ-018 running SHALL equal (state == RUN).

Reset
REQ-019 Reset SHALL asynchronously force state IDLE, load=0, count_en=0, up=1, data_in=0, running=0, prescaler=0, all synchronizer/debounce flops and debounced levels to 0.
REQ-020 Reset asserted mid-RUN or mid-LOAD SHALL abort the operation with no further load or count_en pulse; a button held through reset release produces one event once debounced.

Configuration
REQ-021 With CMD_STEP_EN defined, SHALL add input btn_step (1 bit, raw), synchronized and debounced like other buttons; a step event in IDLE gives one count_en pulse next cycle; ignored in LOAD and RUN; loses to a simultaneous load or run event.
REQ-022 Without CMD_STEP_EN, btn_step port and its logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-023 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2) and default constants for DEB_CYCLES and TICK_DIV.
REQ-024 Synchronizer+debouncer+edge detect SHALL be sub-module btn_conditioner, instantiated once per button.

Verification
REQ-025 Reset asserted then released, no buttons -> load=0, count_en=0, up=1, data_in=0, running=0.
REQ-026 sw_data=4'h6, btn_load held 20 cycles -> exactly one load pulse, data_in=4'h6 that cycle, state returns IDLE.
REQ-027 btn_run pressed, TICK_DIV=10 -> running=1, count_en pulses every 10 cycles, 4 pulses in 40 cycles; second btn_run press -> running=0, no further pulses.
REQ-028 In RUN, btn_dir pressed -> up 1->0, running stays 1, pulse spacing unchanged.
REQ-029 btn_load and btn_run pressed same cycle in IDLE -> one load pulse, state IDLE, running=0; btn_load glitch of 2 cycles (< DEB_CYCLES=4) -> no event.
REQ-030 Reset pulse during RUN one cycle before a scheduled count_en -> no count_en, all outputs at reset values.

Source files
------------

// File: rtl/counter_cmd_ctrl_pkg.sv
// counter_cmd_ctrl shared types and defaults.
// FSM state encoding plus default timing constants.
package counter_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_TICK_DIV   = 10;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_cmd_ctrl_btn_conditioner.sv
// btn_conditioner: 2-flop synchronizer, debouncer and
// rising-edge detector for one raw push button.
module btn_conditioner
  import counter_cmd_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_lvl_q;
  logic [CW-1:0] r_cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after a full run of equal samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == CMAX) begin
      r_lvl <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed level for the press edge detector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lvl_q <= 1'b0;
    else       r_lvl_q <= r_lvl;
  end

  assign o_press = r_lvl & ~r_lvl_q;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: button-driven load/run/direction control for
// a downstream counter. Optional step button under CMD_STEP_EN.
module counter_cmd_ctrl
  import counter_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             btn_load,
  input  logic             btn_run,
  input  logic             btn_dir,
`ifdef CMD_STEP_EN
  input  logic             btn_step,
`endif
  input  logic [WIDTH-1:0] sw_data,
  output logic             load,
  output logic             count_en,
  output logic             up,
  output logic [WIDTH-1:0] data_in,
  output logic             running
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic w_ev_load;
  logic w_ev_run;
  logic w_ev_dir;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_load (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_btn   (btn_load),
    .o_press (w_ev_load)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_btn   (btn_run),
    .o_press (w_ev_run)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_dir (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_btn   (btn_dir),
    .o_press (w_ev_dir)
  );

`ifdef CMD_STEP_EN
  logic w_ev_step;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_btn   (btn_step),
    .o_press (w_ev_step)
  );
`endif

  logic [WIDTH-1:0] r_sw1;
  logic [WIDTH-1:0] r_sw2;
  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_cen_nxt;
  logic             w_capture;
  logic             r_load;
  logic             r_cen;
  logic             r_up;
  logic [WIDTH-1:0] r_data;
  logic             r_running;

  // Synchronize the switch bus before it is captured.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sw1 <= '0;
      r_sw2 <= '0;
    end else begin
      r_sw1 <= sw_data;
      r_sw2 <= r_sw1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state, prescaler and pulse decisions; load beats run.
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_cen_nxt   = 1'b0;
    w_presc_nxt = '0;
    unique case (r_state)
      IDLE: begin
        if (w_ev_load) begin
          w_next    = LOAD;
          w_capture = 1'b1;
        end else if (w_ev_run) begin
          w_next = RUN;
        end
`ifdef CMD_STEP_EN
        else if (w_ev_step) begin
          w_cen_nxt = 1'b1;
        end
`endif
      end
      LOAD: begin
        w_next = IDLE;
      end
      RUN: begin
        if (w_ev_load) begin
          w_next    = LOAD;
          w_capture = 1'b1;
        end else if (w_ev_run) begin
          w_next = IDLE;
        end else if (r_presc == PMAX) begin
          w_cen_nxt = 1'b1;
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Prescaler; zero whenever not continuing in RUN.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_presc <= '0;
    else       r_presc <= w_presc_nxt;
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_load    <= 1'b0;
      r_cen     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_load    <= (w_next == LOAD);
      r_cen     <= w_cen_nxt;
      r_running <= (w_next == RUN);
    end
  end

  // Capture the switch value on the load event.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)          r_data <= '0;
    else if (w_capture) r_data <= r_sw2;
  end

  // Direction toggles on every dir press, in any state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_up <= 1'b1;
    else       r_up <= r_up ^ w_ev_dir;
  end

  assign load     = r_load;
  assign count_en = r_cen;
  assign up       = r_up;
  assign data_in  = r_data;
  assign running  = r_running;

endmodule
